// File: rtl/wake_sched_wheel_pkg.sv
// Shared types and sizing for the wakeup timing wheel.
// One slot holds the two broadcast lanes that drain in the same cycle.
package wake_sched_wheel_pkg;

  localparam int PREG_W      = 6;
  localparam int LAT_W       = 3;
  localparam int WHEEL_DEPTH = 1 << LAT_W;

  typedef struct packed {
    logic              vld;
    logic [PREG_W-1:0] pd;
  } wake_lane_t;

  typedef struct packed {
    wake_lane_t [1:0] lane;
  } wake_slot_t;

endpackage

// File: rtl/wake_slot_alloc.sv
// Lane allocator for the two issue ports.
// Port 0 has priority; port 1 sees port 0's lane when both hit one slot.
module wake_slot_alloc
  import wake_sched_wheel_pkg::*;
(
  input  logic [1:0] occ0,
  input  logic [1:0] occ1,
  input  logic       same_slot,
  input  logic       req0,
  input  logic       req1,
  input  logic       need0,
  input  logic       need1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       lane0,
  output logic       lane1
);

  logic [1:0] eff1;

  always_comb begin
    gnt0  = req0 & (~need0 | ~(&occ0));
    lane0 = occ0[0];
    eff1  = occ1;
    // pd==0 grants take no lane, so only a real port-0 allocation blocks port 1
    if (same_slot && gnt0 && need0) begin
      eff1[lane0] = 1'b1;
    end
    gnt1  = req1 & (~need1 | ~(&eff1));
    lane1 = eff1[0];
  end

endmodule

// File: rtl/wake_sched_wheel.sv
// Wakeup broadcast scheduler: reserves a wake-bus lane exactly lat cycles ahead
// on an 8-slot timing wheel and drains one slot per cycle onto two lanes.
module wake_sched_wheel
  import wake_sched_wheel_pkg::*;
#(
  parameter int PREG_W = wake_sched_wheel_pkg::PREG_W,
  parameter int LAT_W  = wake_sched_wheel_pkg::LAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss0_vld,
  input  logic [PREG_W-1:0] iss0_pd,
  input  logic [LAT_W-1:0]  iss0_lat,
  output logic              iss0_gnt,
  input  logic              iss1_vld,
  input  logic [PREG_W-1:0] iss1_pd,
  input  logic [LAT_W-1:0]  iss1_lat,
  output logic              iss1_gnt,
  output logic              wake_vld0,
  output logic [PREG_W-1:0] wake_pd0,
  output logic              wake_vld1,
  output logic [PREG_W-1:0] wake_pd1
);

  wake_slot_t        wheel_q [WHEEL_DEPTH];
  wake_slot_t        wheel_d [WHEEL_DEPTH];
  logic [LAT_W-1:0]  hp_q, hp_d, hp_nxt;
  logic [LAT_W-1:0]  tgt0, tgt1;
  logic              wake_vld0_q, wake_vld0_d, wake_vld1_q, wake_vld1_d;
  logic [PREG_W-1:0] wake_pd0_q, wake_pd0_d, wake_pd1_q, wake_pd1_d;
  logic [1:0]        occ0, occ1;
  logic              req0, req1, need0, need1;
  logic              gnt0, gnt1, lane0, lane1;
  wake_slot_t        drain;

  assign hp_nxt = hp_q + LAT_W'(1);
  assign tgt0   = hp_q + iss0_lat;
  assign tgt1   = hp_q + iss1_lat;
  assign occ0   = {wheel_q[tgt0].lane[1].vld, wheel_q[tgt0].lane[0].vld};
  assign occ1   = {wheel_q[tgt1].lane[1].vld, wheel_q[tgt1].lane[0].vld};
  assign req0   = iss0_vld & (|iss0_lat) & ~flush & ~rst;
  assign req1   = iss1_vld & (|iss1_lat) & ~flush & ~rst;
  assign need0  = |iss0_pd;
  assign need1  = |iss1_pd;

  wake_slot_alloc u_alloc (
    .occ0      (occ0),
    .occ1      (occ1),
    .same_slot (tgt0 == tgt1),
    .req0      (req0),
    .req1      (req1),
    .need0     (need0),
    .need1     (need1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .lane0     (lane0),
    .lane1     (lane1)
  );

  assign iss0_gnt = gnt0;
  assign iss1_gnt = gnt1;

  // Writes land before the drain read so lat==1 reservations bypass straight out
  always_comb begin
    for (int i = 0; i < WHEEL_DEPTH; i++) begin
      wheel_d[i] = wheel_q[i];
    end
    if (gnt0 && need0) begin
      wheel_d[tgt0].lane[lane0].vld = 1'b1;
      wheel_d[tgt0].lane[lane0].pd  = iss0_pd;
    end
    if (gnt1 && need1) begin
      wheel_d[tgt1].lane[lane1].vld = 1'b1;
      wheel_d[tgt1].lane[lane1].pd  = iss1_pd;
    end
    drain            = wheel_d[hp_nxt];
    wheel_d[hp_nxt]  = '0;
    hp_d             = hp_nxt;
    wake_vld0_d      = drain.lane[0].vld;
    wake_vld1_d      = drain.lane[1].vld;
    wake_pd0_d       = drain.lane[0].vld ? drain.lane[0].pd : wake_pd0_q;
    wake_pd1_d       = drain.lane[1].vld ? drain.lane[1].pd : wake_pd1_q;
    if (flush) begin
      for (int i = 0; i < WHEEL_DEPTH; i++) begin
        wheel_d[i] = '0;
      end
      wake_vld0_d = 1'b0;
      wake_vld1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WHEEL_DEPTH; i++) begin
        wheel_q[i] <= '0;
      end
      hp_q        <= '0;
      wake_vld0_q <= 1'b0;
      wake_vld1_q <= 1'b0;
      wake_pd0_q  <= '0;
      wake_pd1_q  <= '0;
    end else begin
      for (int i = 0; i < WHEEL_DEPTH; i++) begin
        wheel_q[i] <= wheel_d[i];
      end
      hp_q        <= hp_d;
      wake_vld0_q <= wake_vld0_d;
      wake_vld1_q <= wake_vld1_d;
      wake_pd0_q  <= wake_pd0_d;
      wake_pd1_q  <= wake_pd1_d;
    end
  end

  assign wake_vld0 = wake_vld0_q;
  assign wake_vld1 = wake_vld1_q;
  assign wake_pd0  = wake_pd0_q;
  assign wake_pd1  = wake_pd1_q;

endmodule

// File: doc/wake_sched_wheel.md
# wake_sched_wheel

- Producer side of the physical-register wakeup broadcast.
- Accepts issue-time reservations from fixed-latency functional-unit pipelines and broadcasts each destination physical register on a 2-lane wake bus exactly `lat` cycles later.
- Bus reservation uses an 8-slot timing wheel, so no two completions ever collide on a lane.
- Sits between the issue stage and the wakeup scoreboard's wake inputs (`Phydst`/`wake` pairs).

## Interface
Parameters:
- PREG_W, 6, physical register index width
- LAT_W, 3, latency field width; wheel depth = 2**LAT_W = 8 slots

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush; discards all pending reservations
- iss0_vld  in  1  port-0 reservation request
- iss0_pd  in  PREG_W  port-0 destination physical register
- iss0_lat  in  LAT_W  port-0 latency, 1..7
- iss0_gnt  out  1  port-0 reservation accepted (combinational)
- iss1_vld, iss1_pd, iss1_lat, iss1_gnt  same as port 0, lower priority
- wake_vld0  out  1  lane-0 broadcast valid (registered)
- wake_pd0  out  PREG_W  lane-0 broadcast register
- wake_vld1  out  1  lane-1 broadcast valid (registered)
- wake_pd1  out  PREG_W  lane-1 broadcast register

## Operation
- State:
  - Wheel of 8 slots × 2 lanes; each lane holds {valid, pd}.
  - Head pointer hp (LAT_W bits).
- Target slot for a request = (hp + lat) mod 8.
- Grant, port 0: iss0_gnt = iss0_vld & lat≠0 & !flush & (pd==0 | target slot has a free lane).
- Grant, port 1: same rule, counting the lane already taken by a port-0 grant when both target the same slot.
- Request refused: no state change. The requester retries next cycle; its target index shifts because hp advances.
- lat==0: never granted.
- pd==0: granted but consumes no lane and is never broadcast (p0 is permanently ready).
- Lane fill order within a slot: lane 0 first, then lane 1. When both ports land in an empty slot, port 0 takes lane 0.
- Every cycle, unconditionally (no stall input; pipelines never stop):
  - wake regs <= slot[hp+1], merged with same-cycle writes targeting hp+1.
  - slot[hp+1] is cleared.
  - hp <= hp+1, wrapping 7→0.
- Duplicate pd in flight: allowed; each reservation broadcasts independently.
- Flush:
  - All lane valids cleared; wake_vld0/1 low in the following cycle.
  - Requests in the flush cycle get no grant.
  - hp keeps advancing.
- Reset and flush asserted together: reset wins (all state to reset values).

## Timing
- Reset values: all lane valids 0, hp=0, wake_vld0=wake_vld1=0, wake_pd0=wake_pd1=0. iss*_gnt are combinational and therefore 0 while rst is high.
- Latency: a grant in cycle t with lat L drives wake_vld in cycle t+L, for L in 1..7.
- L=1: written and read in the same edge; the bypass is required.
- wake_pd holds its last value when wake_vld=0. Consumers must qualify with wake_vld.
- Capacity: at most 2 broadcasts per slot per cycle, and at most 2 grants per cycle.
- The wheel never overflows. With L ≤ 7 and 8 slots, index hp (just drained) is never a target.

## Structure
- Shared package:
  - PREG_W, LAT_W, WHEEL_DEPTH
  - wake_lane_t {vld, pd}
  - wake_slot_t {lane[2]}
- Sub-module wake_slot_alloc, combinational:
  - Inputs: target-slot occupancy for both ports, plus same-slot indication.
  - Outputs: grants and lane indices.
- Top-level holds the wheel registers, hp, the read/bypass mux, and the output registers.

## Test plan
- Reset, then iss0 pd=5 lat=3 in cycle 2 → iss0_gnt=1; wake_vld0=1, wake_pd0=5 in cycle 5 only; wake_vld1=0 throughout.
- Same cycle: iss0 pd=7 lat=1 and iss1 pd=9 lat=1 → both granted; next cycle wake_pd0=7, wake_pd1=9, both valid (bypass path).
- Slot full: cycle t grants pd=10 lat=4 and pd=11 lat=4 (two ports); cycle t+1 iss0 pd=12 lat=3, which targets the same slot → iss0_gnt=0. Retry in t+2 with lat=3 → granted, wakes in t+5.
- Edge grants: iss0 pd=0 lat=2 → gnt=1, no wake ever. iss1 pd=4 lat=0 → gnt=0.
- Flush: grant pd=20 lat=6, then flush at +2 → no wake for pd=20. A request in the flush cycle gets gnt=0. A request one cycle after flush, lat=2 → wakes normally.
- Wrap-around: 20 consecutive cycles with iss0 lat=7 and incrementing pd → every pd broadcast exactly 7 cycles after its grant, in order, across multiple hp wraps.
